muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, meaning operand and result width in bits (even, >= 8).
REQ-002 The block SHALL expose parameter TAG_W, default 5, meaning width of the pass-through destination tag.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1  request present.
REQ-006 Port in_ready  output  1  block can accept a request.
REQ-007 Port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 Port a, b  input  XLEN each  rs1 and rs2 operands.
REQ-009 Port in_tag  input  TAG_W  opaque tag, returned with the result.
REQ-010 Port flush  input  1  abort any in-flight operation.
REQ-011 Port out_valid  output  1  result present.
REQ-012 Port out_ready  input  1  consumer accepts result.
REQ-013 Port result  output  XLEN  operation result.
REQ-014 Port out_tag  output  TAG_W  tag of the result.
REQ-015 Port busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, CALC, DONE; in_ready = (state == IDLE) and is independent of in_valid.
REQ-017 Acceptance SHALL occur on an edge where in_valid && in_ready; op, a, b and in_tag SHALL be latched on that edge.
REQ-018 On acceptance, ordinary ops SHALL go IDLE -> CALC, iterate one bit per cycle for exactly XLEN cycles, then go to DONE.
REQ-019 Latency SHALL be XLEN+1 cycles from the accept edge to the first edge with out_valid high.
REQ-020 Multiply SHALL be a shift-add over operand magnitudes with sign correction, producing a 2*XLEN-bit product.
REQ-021 MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-022 MULH SHALL treat a and b as signed, MULHSU SHALL treat a as signed and b as unsigned, and MULHU SHALL treat both as unsigned.
REQ-023 Divide SHALL be restoring division on magnitudes; quotient is negated iff signs differ, remainder takes the sign of the dividend (DIV/REM signed, DIVU/REMU unsigned).
REQ-024 If b == 0, the block SHALL skip CALC: quotient = all ones, remainder = a, and it SHALL go IDLE -> DONE with latency 1.
REQ-025 For signed overflow (DIV/REM with a = 1 followed by XLEN-1 zeros and b = all ones), the block SHALL skip CALC: quotient = a, remainder = 0, latency 1.
REQ-026 In DONE, out_valid SHALL be high and result/out_tag SHALL be held stable until the out_ready edge, after which the block SHALL return to IDLE.
REQ-027 A new request SHALL NOT be accepted on the same edge a result is retired; in_ready rises the cycle after.
REQ-028 flush high SHALL force IDLE on the next edge from any state, drop any pending result and deassert out_valid; flush has priority over in_valid and out_ready.
REQ-029 A request presented with in_valid and flush both high SHALL NOT be accepted.
REQ-030 Operands SHALL NOT be sampled outside the accept edge; input changes during CALC SHALL have no effect.

Reset
REQ-031 With rst high on an edge, state SHALL become IDLE, out_valid = 0, result = 0, out_tag = 0, busy = 0, and in_ready SHALL be 1 in the following cycle.
REQ-032 Reset SHALL take priority over flush and handshakes and SHALL abort mid-CALC operations with no output.

Verification
REQ-033 For XLEN=32: MULH a=0xFFFFFFFE, b=3 -> result 0xFFFFFFFF after exactly 33 cycles; MUL with the same operands -> 0xFFFFFFFA.
REQ-034 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-036 DIVU a=0x1234, b=0 -> 0xFFFFFFFF after 1 cycle; REM a=0x1234, b=0 -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-037 Hold out_ready low for 5 cycles in DONE -> result, out_tag and out_valid stable; in_ready stays low.
REQ-038 Assert flush at CALC cycle 10, then rst at CALC cycle 10 of a second op -> no out_valid, IDLE next cycle; a following request completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   Multiplies by shift-add and divides by restoring division, one bit per
//   cycle over operand magnitudes, with sign correction applied as the last
//   iteration retires. Division by zero and signed overflow bypass the
//   iteration and complete in a single cycle.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      request handshake (in_ready only in IDLE)
//   op, a, b, in_tag       funct3, rs1, rs2, opaque tag
//   flush                  abort in-flight work and drop any pending result
//   out_valid/out_ready    result handshake
//   result, out_tag        result value and its tag
//   busy                   high whenever the FSM is not IDLE
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t             state;
  logic [2:0]         op_q;
  logic [TAG_W-1:0]   tag_q;
  logic [2*XLEN-1:0]  acc;    // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]    m;      // multiplicand or divisor magnitude
  logic               neg_q;  // negate product / quotient
  logic               neg_r;  // negate remainder
  logic [CNT_W-1:0]   cnt;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Request decode: signedness, magnitudes and single-cycle special cases.
  logic            a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  // NOTE: every always_comb output gets a default on entry so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    a_neg       = 1'b0;
    b_neg       = 1'b0;
    special_res = '0;
    // Signed rs1: MULH, MULHSU, DIV, REM. Signed rs2: MULH, DIV, REM.
    // MUL is handled unsigned since the low half is sign-agnostic.
    if (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110)
      a_neg = a[XLEN-1];
    if (op == 3'b001 || op == 3'b100 || op == 3'b110)
      b_neg = b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = op[2] && (b == '0);
    div_ovf  = op[2] && !op[0] && (a == INT_MIN) && (b == '1);
    if (div_zero)
      special_res = op[1] ? a : '1;
    else
      special_res = op[1] ? '0 : a;
  end

  // One iteration of the datapath plus the signed result of the final step.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_nxt, prod;
  logic [XLEN-1:0]   quo, rem, final_res;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, m};
    if (op_q[2]) begin
      // A borrow out of the trial subtraction means restore the remainder.
      if (div_diff[XLEN])
        acc_nxt = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    end
    prod = neg_q ? -acc_nxt : acc_nxt;
    quo  = acc_nxt[XLEN-1:0];
    rem  = acc_nxt[2*XLEN-1:XLEN];
    if (!op_q[2])
      final_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op_q[1])
      final_res = neg_r ? -rem : rem;
    else
      final_res = neg_q ? -quo : quo;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset as well so the unit starts from a
      // fully known state; the visible outputs must read zero after reset.
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      acc       <= '0;
      m         <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      cnt       <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (div_zero || div_ovf) begin
            result    <= special_res;
            out_tag   <= in_tag;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            op_q  <= op;
            tag_q <= in_tag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            acc   <= {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
            m     <= op[2] ? b_mag : a_mag;
            cnt   <= CNT_W'(XLEN - 1);
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          if (cnt == '0) begin
            result    <= final_res;
            out_tag   <= tag_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [31:0] a, b, result;
  logic [4:0]  in_tag, out_tag;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_tag(out_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Issue one request, scramble inputs during computation, measure latency,
  // optionally stall in DONE, then retire with a competing request present.
  // Entered and left just after a falling edge.
  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [4:0] t, input logic [31:0] exp, input int exp_lat,
                     input int hold, input string name);
    int n;
    op = o; a = x; b = y; in_tag = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~o; a = $urandom; b = $urandom; in_tag = ~t;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    check({name, " result"}, {32'h0, result}, {32'h0, exp});
    check({name, " tag"}, {59'h0, out_tag}, {59'h0, t});
    check({name, " in_ready in DONE"}, {63'h0, in_ready}, 64'h0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, " stall out_valid"}, {63'h0, out_valid}, 64'h1);
      check({name, " stall result"}, {32'h0, result}, {32'h0, exp});
      check({name, " stall tag"}, {59'h0, out_tag}, {59'h0, t});
      check({name, " stall in_ready"}, {63'h0, in_ready}, 64'h0);
    end
    out_ready = 1'b1; in_valid = 1'b1; op = MUL; a = 32'h5; b = 32'h7;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check({name, " retire out_valid"}, {63'h0, out_valid}, 64'h0);
    check({name, " retire in_ready"}, {63'h0, in_ready}, 64'h1);
    check({name, " no accept on retire"}, {63'h0, busy}, 64'h0);
  endtask

  // Confirm no result appears for a number of cycles after an abort.
  task automatic quiet(input int cycles, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check({name, " no output"}, {63'h0, seen}, 64'h0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", {63'h0, in_ready}, 64'h1);
    check("reset busy", {63'h0, busy}, 64'h0);
    check("reset out_valid", {63'h0, out_valid}, 64'h0);
    check("reset result", {32'h0, result}, 64'h0);
    check("reset out_tag", {59'h0, out_tag}, 64'h0);

    run(MULH,   32'hFFFFFFFE, 32'h00000003, 5'd1,  32'hFFFFFFFF, 33, 0, "MULH -2*3");
    run(MUL,    32'hFFFFFFFE, 32'h00000003, 5'd2,  32'hFFFFFFFA, 33, 5, "MUL -2*3");
    run(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 33, 0, "MULHU max*max");
    run(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 33, 0, "MULHSU -1*max");
    run(MULH,   32'h80000000, 32'h80000000, 5'd5,  32'h40000000, 33, 0, "MULH min*min");
    run(DIV,    32'hFFFFFFF9, 32'h00000002, 5'd6,  32'hFFFFFFFD, 33, 0, "DIV -7/2");
    run(REM,    32'hFFFFFFF9, 32'h00000002, 5'd7,  32'hFFFFFFFF, 33, 0, "REM -7/2");
    run(DIV,    32'h00000007, 32'hFFFFFFFE, 5'd8,  32'hFFFFFFFD, 33, 0, "DIV 7/-2");
    run(REM,    32'h00000007, 32'hFFFFFFFE, 5'd9,  32'h00000001, 33, 0, "REM 7/-2");
    run(DIVU,   32'd100,      32'd7,        5'd10, 32'd14,       33, 0, "DIVU 100/7");
    run(REMU,   32'd100,      32'd7,        5'd11, 32'd2,        33, 0, "REMU 100/7");
    run(DIVU,   32'hFFFFFFFF, 32'h00000001, 5'd12, 32'hFFFFFFFF, 33, 0, "DIVU max/1");
    run(DIVU,   32'h00001234, 32'h00000000, 5'd13, 32'hFFFFFFFF, 1,  0, "DIVU by zero");
    run(REM,    32'h00001234, 32'h00000000, 5'd14, 32'h00001234, 1,  0, "REM by zero");
    run(DIV,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1,  0, "DIV overflow");
    run(REM,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 1,  0, "REM overflow");

    // Flush ten cycles into a computation, with a competing request present.
    op = MULHU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_tag = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check("flush busy", {63'h0, busy}, 64'h0);
    check("flush out_valid", {63'h0, out_valid}, 64'h0);
    check("flush in_ready", {63'h0, in_ready}, 64'h1);
    // Still flushing while IDLE: the presented request must be refused.
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush blocks accept", {63'h0, busy}, 64'h0);
    quiet(40, "after flush");

    // Reset ten cycles into a second computation.
    op = DIVU; a = 32'd1000; b = 32'd3; in_tag = 5'd21; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-calc reset busy", {63'h0, busy}, 64'h0);
    check("mid-calc reset in_ready", {63'h0, in_ready}, 64'h1);
    check("mid-calc reset result", {32'h0, result}, 64'h0);
    check("mid-calc reset out_tag", {59'h0, out_tag}, 64'h0);
    quiet(40, "after reset");

    run(DIVU, 32'd100, 32'd7, 5'd22, 32'd14, 33, 0, "DIVU after abort");

    // A pending result is dropped by flush even with out_ready low.
    op = DIVU; a = 32'h1234; b = 32'h0; in_tag = 5'd23; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("DONE before flush", {63'h0, out_valid}, 64'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush drops result", {63'h0, out_valid}, 64'h0);
    check("flush returns IDLE", {63'h0, in_ready}, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
